mem_wb_stage: RTL and testbench

Parametrised successor to the fixed MemWB pipeline stage. Accepts one retiring instruction per handshake. For loads, waits for the data memory response, then aligns and sign/zero-extends it, and produces a single-cycle register-file write. Keeps a commit-advanced history shift register of the last HIST_DEPTH writebacks and uses it for a combinational forwarding lookup. Sits between the execute stage and the register file.

---
 rtl/mem_wb_pkg.sv | 21 ++
 rtl/mem_wb_stage_load_align.sv | 27 ++
 rtl/mem_wb_stage.sv | 109 ++++++++++
 tb/tb_mem_wb_stage.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/mem_wb_pkg.sv
// Shared types for the memory/writeback stage: FSM states, load size codes, history entry.
package mem_wb_pkg;

   typedef enum logic {IDLE = 1'b0, WAIT_MEM = 1'b1} MemWbState;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   // History rd field is sized for up to 32 architectural registers.
   localparam int HIST_RD_W = 5;

   typedef struct packed {
      logic                 valid;
      logic [HIST_RD_W-1:0] rd;
      logic [31:0]          data;
   } HistEntry;

endpackage

// File: rtl/mem_wb_stage_load_align.sv
// Combinational load data alignment: lane select by address, then sign/zero extend.
module load_align
   import mem_wb_pkg::*;
(
   input  logic [31:0] mem_rdata,
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   output logic [31:0] data
);

   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   always_comb begin
      lane_b = mem_rdata[{addr_lo, 3'b000} +: 8];
      lane_h = addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (funct3)
         F3_LB:   data = {{24{lane_b[7]}}, lane_b};
         F3_LBU:  data = {24'd0, lane_b};
         F3_LH:   data = {{16{lane_h[15]}}, lane_h};
         F3_LHU:  data = {16'd0, lane_h};
         F3_LW:   data = mem_rdata;
         default: data = mem_rdata;
      endcase
   end

endmodule

// File: rtl/mem_wb_stage.sv
// Memory/writeback stage: waits for load data, aligns it, emits a one-cycle regfile write
// and keeps a commit-advanced writeback history used for forwarding.
module mem_wb_stage
   import mem_wb_pkg::*;
#(
   parameter int REG_COUNT  = 32,
   parameter int HIST_DEPTH = 2,
   localparam int REG_W     = $clog2(REG_COUNT)
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic                            in_is_load,
   input  logic [2:0]                      in_funct3,
   input  logic [1:0]                      in_addr_lo,
   input  logic [REG_W-1:0]                in_rd,
   input  logic [31:0]                     in_result,
   input  logic                            flush,
   input  logic                            mem_rvalid,
   input  logic [31:0]                     mem_rdata,
   output logic                            regs_write_out,
   output logic [REG_W-1:0]                regs_wr_id_out,
   output logic [31:0]                     regs_data_out,
   input  logic [REG_W-1:0]                fwd_rd_in,
   output logic                            fwd_hit,
   output logic [31:0]                     fwd_data,
   output HistEntry [HIST_DEPTH-1:0]       hist_out
);

   MemWbState          state;
   logic [REG_W-1:0]   rd_q;
   logic [2:0]         f3_q;
   logic [1:0]         lo_q;
   logic [31:0]        aligned;
   logic               accept;
   logic               commit;
   logic [REG_W-1:0]   c_rd;
   logic [31:0]        c_data;

   load_align u_align (
      .mem_rdata (mem_rdata),
      .funct3    (f3_q),
      .addr_lo   (lo_q),
      .data      (aligned)
   );

   assign in_ready = (state == IDLE) && reset;
   assign accept   = in_valid && in_ready && !flush;

   // rd==0 commits are architecturally invisible: no strobe, no history push.
   always_comb begin
      commit = 1'b0;
      c_rd   = in_rd;
      c_data = in_result;
      if (state == IDLE) begin
         commit = accept && !in_is_load && (in_rd != '0);
      end else begin
         c_rd   = rd_q;
         c_data = aligned;
         commit = mem_rvalid && !flush && (rd_q != '0);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state          <= IDLE;
         rd_q           <= '0;
         f3_q           <= '0;
         lo_q           <= '0;
         regs_write_out <= 1'b0;
         regs_wr_id_out <= '0;
         regs_data_out  <= '0;
         hist_out       <= '0;
      end else begin
         regs_write_out <= commit;
         if (commit) begin
            regs_wr_id_out <= c_rd;
            regs_data_out  <= c_data;
            for (int i = HIST_DEPTH - 1; i > 0; i--) hist_out[i] <= hist_out[i-1];
            hist_out[0] <= '{valid: 1'b1, rd: HIST_RD_W'(c_rd), data: c_data};
         end
         case (state)
            IDLE: if (accept && in_is_load) begin
               state <= WAIT_MEM;
               rd_q  <= in_rd;
               f3_q  <= in_funct3;
               lo_q  <= in_addr_lo;
            end
            WAIT_MEM: if (flush || mem_rvalid) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Scan oldest to newest so the lowest matching index ends up selected.
   always_comb begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
      for (int i = HIST_DEPTH - 1; i >= 0; i--) begin
         if (hist_out[i].valid && (fwd_rd_in != '0) &&
             (hist_out[i].rd == HIST_RD_W'(fwd_rd_in))) begin
            fwd_hit  = 1'b1;
            fwd_data = hist_out[i].data;
         end
      end
   end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: reset, ALU writeback, load alignment, flush, history, async reset.
module tb_mem_wb_stage;
   import mem_wb_pkg::*;

   logic            clk = 1'b0;
   logic            reset;
   logic            in_valid, in_is_load, flush, mem_rvalid;
   logic            in_ready;
   logic [2:0]      in_funct3;
   logic [1:0]      in_addr_lo;
   logic [4:0]      in_rd, regs_wr_id_out, fwd_rd_in;
   logic [31:0]     in_result, mem_rdata, regs_data_out, fwd_data;
   logic            regs_write_out, fwd_hit;
   HistEntry [1:0]  hist_out;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mem_wb_stage #(.REG_COUNT(32), .HIST_DEPTH(2)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_is_load(in_is_load), .in_funct3(in_funct3), .in_addr_lo(in_addr_lo),
      .in_rd(in_rd), .in_result(in_result), .flush(flush), .mem_rvalid(mem_rvalid),
      .mem_rdata(mem_rdata), .regs_write_out(regs_write_out),
      .regs_wr_id_out(regs_wr_id_out), .regs_data_out(regs_data_out),
      .fwd_rd_in(fwd_rd_in), .fwd_hit(fwd_hit), .fwd_data(fwd_data), .hist_out(hist_out)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0; in_valid = 0; in_is_load = 0; flush = 0; mem_rvalid = 0;
      in_funct3 = 0; in_addr_lo = 0; in_rd = 0; in_result = 0; mem_rdata = 0; fwd_rd_in = 0;
      #23;
      checks++; if (regs_write_out !== 1'b0 || regs_wr_id_out !== 5'd0 || regs_data_out !== 32'd0) begin
         failures++; $display("FAIL reset_outputs got %b/%0d/%h want 0/0/0", regs_write_out, regs_wr_id_out, regs_data_out); end
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_ready_low got %b want 0", in_ready); end
      checks++; if (hist_out !== '0) begin failures++; $display("FAIL reset_hist got %h want 0", hist_out); end
      reset = 1'b1;
      step();
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL ready_after_reset got %b want 1", in_ready); end
   endtask

   task automatic test_alu();
      in_valid = 1; in_is_load = 0; in_rd = 5; in_result = 32'h1234;
      step();
      in_valid = 0; fwd_rd_in = 5;
      #1;
      checks++; if (regs_write_out !== 1'b1 || regs_wr_id_out !== 5'd5 || regs_data_out !== 32'h1234) begin
         failures++; $display("FAIL alu_write got %b/%0d/%h want 1/5/00001234", regs_write_out, regs_wr_id_out, regs_data_out); end
      checks++; if (hist_out[0] !== {1'b1, 5'd5, 32'h1234}) begin
         failures++; $display("FAIL alu_hist0 got %h want 1/5/00001234", hist_out[0]); end
      checks++; if (fwd_hit !== 1'b1 || fwd_data !== 32'h1234) begin
         failures++; $display("FAIL alu_fwd got %b/%h want 1/00001234", fwd_hit, fwd_data); end
      step();
      checks++; if (regs_write_out !== 1'b0) begin failures++; $display("FAIL alu_one_cycle got %b want 0", regs_write_out); end
   endtask

   task automatic test_load_align();
      logic [2:0]  f3 [4]  = '{3'b000, 3'b100, 3'b001, 3'b101};
      logic [1:0]  lo [4]  = '{2'd2, 2'd2, 2'd3, 2'd0};
      logic [4:0]  rd [4]  = '{5'd3, 5'd3, 5'd6, 5'd8};
      logic [31:0] wd [4]  = '{32'h0080_0000, 32'h0080_0000, 32'h8001_7FFF, 32'h8001_7FFF};
      logic [31:0] ex [4]  = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001, 32'h0000_7FFF};
      for (int k = 0; k < 4; k++) begin
         in_valid = 1; in_is_load = 1; in_funct3 = f3[k]; in_addr_lo = lo[k]; in_rd = rd[k];
         step();
         in_valid = 0; in_funct3 = 3'b010; in_addr_lo = 0;
         for (int w = 0; w < 3; w++) begin
            checks++; if (in_ready !== 1'b0 || regs_write_out !== 1'b0) begin
               failures++; $display("FAIL load%0d_wait%0d ready/write got %b/%b want 0/0", k, w, in_ready, regs_write_out); end
            if (w < 2) step();
         end
         mem_rvalid = 1; mem_rdata = wd[k];
         step();
         mem_rvalid = 0; mem_rdata = 32'hDEAD_BEEF;
         checks++; if (regs_write_out !== 1'b1 || regs_wr_id_out !== rd[k] || regs_data_out !== ex[k]) begin
            failures++; $display("FAIL load%0d_data got %b/%0d/%h want 1/%0d/%h", k, regs_write_out, regs_wr_id_out, regs_data_out, rd[k], ex[k]); end
         checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL load%0d_ready got %b want 1", k, in_ready); end
      end
      step();
   endtask

   task automatic test_flush();
      in_valid = 1; in_is_load = 1; in_funct3 = 3'b010; in_rd = 4;
      step();
      in_valid = 0;
      step();
      flush = 1; mem_rvalid = 1; mem_rdata = 32'h5555_AAAA;
      step();
      flush = 0;
      checks++; if (regs_write_out !== 1'b0) begin failures++; $display("FAIL flush_no_write got %b want 0", regs_write_out); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL flush_ready got %b want 1", in_ready); end
      step();
      mem_rvalid = 0;
      checks++; if (regs_write_out !== 1'b0) begin failures++; $display("FAIL rvalid_idle_ignored got %b want 0", regs_write_out); end
      checks++; if (hist_out !== {1'b1, 5'd6, 32'hFFFF_8001, 1'b1, 5'd8, 32'h0000_7FFF}) begin
         failures++; $display("FAIL flush_hist got %h want hist0=8/00007fff hist1=6/ffff8001", hist_out); end
      flush = 1; in_valid = 1; in_is_load = 0; in_rd = 12; in_result = 32'h77;
      step();
      flush = 0; in_valid = 0;
      checks++; if (regs_write_out !== 1'b0) begin failures++; $display("FAIL flush_offer_rejected got %b want 0", regs_write_out); end
   endtask

   task automatic test_back_to_back();
      in_valid = 1; in_is_load = 0; in_rd = 7; in_result = 32'hAAAA_0001;
      step();
      checks++; if (regs_write_out !== 1'b1 || regs_data_out !== 32'hAAAA_0001) begin
         failures++; $display("FAIL b2b_first got %b/%h want 1/aaaa0001", regs_write_out, regs_data_out); end
      in_rd = 7; in_result = 32'hBBBB_0002;
      step();
      fwd_rd_in = 7; #1;
      checks++; if (fwd_hit !== 1'b1 || fwd_data !== 32'hBBBB_0002) begin
         failures++; $display("FAIL fwd_newest_7 got %b/%h want 1/bbbb0002", fwd_hit, fwd_data); end
      in_rd = 9; in_result = 32'hCCCC_0003;
      step();
      checks++; if (regs_write_out !== 1'b1 || regs_wr_id_out !== 5'd9 || regs_data_out !== 32'hCCCC_0003) begin
         failures++; $display("FAIL b2b_third got %b/%0d/%h want 1/9/cccc0003", regs_write_out, regs_wr_id_out, regs_data_out); end
      checks++; if (hist_out !== {1'b1, 5'd7, 32'hBBBB_0002, 1'b1, 5'd9, 32'hCCCC_0003}) begin
         failures++; $display("FAIL hist_drop_oldest got %h want hist0=9/cccc0003 hist1=7/bbbb0002", hist_out); end
      checks++; if (fwd_hit !== 1'b1 || fwd_data !== 32'hBBBB_0002) begin
         failures++; $display("FAIL fwd_7_index1 got %b/%h want 1/bbbb0002", fwd_hit, fwd_data); end
      in_rd = 0; in_result = 32'h1111_1111;
      step();
      in_valid = 0;
      checks++; if (regs_write_out !== 1'b0 || regs_wr_id_out !== 5'd9 || regs_data_out !== 32'hCCCC_0003) begin
         failures++; $display("FAIL rd0_no_write got %b/%0d/%h want 0/9/cccc0003", regs_write_out, regs_wr_id_out, regs_data_out); end
      checks++; if (hist_out[0] !== {1'b1, 5'd9, 32'hCCCC_0003}) begin
         failures++; $display("FAIL rd0_no_shift got %h want 1/9/cccc0003", hist_out[0]); end
      fwd_rd_in = 0; #1;
      checks++; if (fwd_hit !== 1'b0 || fwd_data !== 32'd0) begin
         failures++; $display("FAIL fwd_rd0 got %b/%h want 0/0", fwd_hit, fwd_data); end
      fwd_rd_in = 3; #1;
      checks++; if (fwd_hit !== 1'b0 || fwd_data !== 32'd0) begin
         failures++; $display("FAIL fwd_miss got %b/%h want 0/0", fwd_hit, fwd_data); end
   endtask

   task automatic test_async_reset();
      in_valid = 1; in_is_load = 1; in_funct3 = 3'b010; in_rd = 10;
      step();
      in_valid = 0;
      #2 reset = 1'b0;
      #1;
      checks++; if (regs_write_out !== 1'b0 || regs_wr_id_out !== 5'd0 || regs_data_out !== 32'd0) begin
         failures++; $display("FAIL async_rst_outputs got %b/%0d/%h want 0/0/0", regs_write_out, regs_wr_id_out, regs_data_out); end
      checks++; if (hist_out[0].valid !== 1'b0 || hist_out[1].valid !== 1'b0) begin
         failures++; $display("FAIL async_rst_hist got %b%b want 00", hist_out[1].valid, hist_out[0].valid); end
      #2 reset = 1'b1;
      mem_rvalid = 1; mem_rdata = 32'h1357_9BDF;
      step();
      mem_rvalid = 0;
      checks++; if (regs_write_out !== 1'b0 || in_ready !== 1'b1) begin
         failures++; $display("FAIL async_rst_load_dropped write/ready got %b/%b want 0/1", regs_write_out, in_ready); end
   endtask

   initial begin
      test_reset();
      test_alu();
      test_load_align();
      test_flush();
      test_back_to_back();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
